// File: rtl/priv_1_12_trap_ctrl.sv
// Machine-mode trap controller: holds the M-mode trap CSRs, arbitrates
// exceptions, MRET and interrupts at commit, then sequences the pipeline
// flush and the single-cycle fetch redirect.
//
// Flush handshake: flush_req is high for every cycle the FSM sits in FLUSH.
// The flush completes on the first rising edge at which flush_ack is high.
// flush_ack has no effect in any other state.
// redirect_valid is a one-cycle pulse; redirect_pc is only meaningful
// while it is high.
module priv_1_12_trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic [30:0] ex_cause,
    input  logic [31:0] commit_pc,
    input  logic [31:0] ex_tval,
    input  logic        mret_valid,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic        csr_wen,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state, state_next;

    logic        mstatus_mie, mstatus_mpie;
    logic        meie, mtie, msie;
    logic [31:0] mtvec, mepc, mcause, mtval;
    logic [31:0] target_q;

    logic        in_idle, mei_pend, msi_pend, mti_pend;
    logic        take_ex, take_mret, take_irq, take_trap, csr_we;
    logic [3:0]  irq_code;
    logic [31:0] trap_cause, target;

    // Event arbitration and redirect target selection in IDLE
    always_comb begin
        in_idle   = (state == IDLE);
        mei_pend  = irq_ext   & meie & mstatus_mie;
        msi_pend  = irq_soft  & msie & mstatus_mie;
        mti_pend  = irq_timer & mtie & mstatus_mie;
        take_ex   = in_idle & ex_valid;
        // An exception in the same cycle swallows the MRET.
        take_mret = in_idle & mret_valid & ~ex_valid;
        take_irq  = in_idle & ~ex_valid & ~mret_valid & (mei_pend | msi_pend | mti_pend);
        take_trap = take_ex | take_irq;
        csr_we    = in_idle & csr_wen;
        irq_code  = mei_pend ? 4'd11 : (msi_pend ? 4'd3 : 4'd7);
        trap_cause = take_ex ? {1'b0, ex_cause} : {1'b1, 27'd0, irq_code};
        if (take_mret) begin
            target = mepc;
        end else if (take_irq && mtvec[1:0] == 2'b01) begin
            target = {mtvec[31:2], 2'b00} + {26'd0, irq_code, 2'b00};
        end else begin
            target = {mtvec[31:2], 2'b00};
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (take_trap || take_mret) state_next = FLUSH;
            FLUSH:    if (flush_ack) state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Redirect target is captured at acceptance so later CSR writes cannot move it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            target_q <= 32'd0;
        end else if (take_trap || take_mret) begin
            target_q <= target;
        end
    end

    // CSR state: software writes first, hardware trap/MRET updates override them
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            meie         <= 1'b0;
            mtie         <= 1'b0;
            msie         <= 1'b0;
            mtvec        <= MTVEC_RESET;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            mtval        <= 32'd0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie  <= csr_wdata[3];
                        mstatus_mpie <= csr_wdata[7];
                    end
                    12'h304: begin
                        meie <= csr_wdata[11];
                        mtie <= csr_wdata[7];
                        msie <= csr_wdata[3];
                    end
                    // Reserved modes 2/3 leave the mode field unchanged.
                    12'h305: mtvec  <= {csr_wdata[31:2], csr_wdata[1] ? mtvec[1:0] : csr_wdata[1:0]};
                    12'h341: mepc   <= {csr_wdata[31:2], 2'b00};
                    12'h342: mcause <= csr_wdata;
                    12'h343: mtval  <= csr_wdata;
                    default: ;
                endcase
            end
            if (take_trap) begin
                mepc         <= {commit_pc[31:2], 2'b00};
                mcause       <= trap_cause;
                mtval        <= take_ex ? ex_tval : 32'd0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

    // Combinational CSR read port
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            12'h300: csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
            12'h304: csr_rdata = {20'd0, meie, 3'd0, mtie, 3'd0, msie, 3'd0};
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h343: csr_rdata = mtval;
            12'h344: csr_rdata = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};
            default: csr_rdata = 32'd0;
        endcase
    end

    // Moore outputs decoded from state so reset clears them asynchronously
    always_comb begin
        flush_req      = (state == FLUSH);
        redirect_valid = (state == REDIRECT);
        redirect_pc    = target_q;
        busy           = (state != IDLE);
        fsm_state      = state;
    end

endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// Directed bench for the M-mode trap controller. Expected redirect targets
// are queued when an event is issued; a negedge monitor pops one per
// redirect_valid pulse. CSR contents are checked directly after each event.
module tb_priv_1_12_trap_ctrl;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0040;

    logic        CLK, nRST;
    logic        ex_valid, mret_valid;
    logic [30:0] ex_cause;
    logic [31:0] commit_pc, ex_tval;
    logic        irq_ext, irq_timer, irq_soft;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        flush_req, flush_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [1:0]  fsm_state;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pushed = 0;
    int          pulses = 0;
    int          flush_cnt;

    priv_1_12_trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_cause(ex_cause), .commit_pc(commit_pc), .ex_tval(ex_tval),
        .mret_valid(mret_valid),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .fsm_state(fsm_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic check_csr(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_events();
        ex_valid   = 1'b0;
        mret_valid = 1'b0;
        irq_ext    = 1'b0;
        irq_timer  = 1'b0;
        irq_soft   = 1'b0;
        csr_wen    = 1'b0;
    endtask

    // Monitor: every redirect pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (nRST && redirect_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL redirect_unexpected: got 0x%08h expected no redirect", redirect_pc);
            end else begin
                check("redirect_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        nRST = 1'b0;
        clear_events();
        ex_cause = '0; commit_pc = '0; ex_tval = '0;
        csr_addr = '0; csr_wdata = '0; flush_ack = 1'b1;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flush_req", {31'd0, flush_req}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
        check_csr("rst_mie", 12'h304, 32'd0);
        check_csr("rst_mtvec", 12'h305, MTVEC_RST);
        check_csr("rst_mepc", 12'h341, 32'd0);
        check_csr("rst_mcause", 12'h342, 32'd0);
        check_csr("rst_mtval", 12'h343, 32'd0);
        tick();
        nRST = 1'b1;
        tick();

        // CSR legalization
        csr_write(12'h305, 32'h8000_0100);
        csr_write(12'h305, 32'h8000_0003);
        check_csr("mtvec_mode3_keep", 12'h305, 32'h8000_0000);
        csr_write(12'h305, 32'h8000_0101);
        csr_write(12'h305, 32'h8000_0102);
        check_csr("mtvec_mode2_keep", 12'h305, 32'h8000_0101);
        csr_write(12'h341, 32'h0000_1003);
        check_csr("mepc_align", 12'h341, 32'h0000_1000);
        csr_write(12'h340, 32'h1234_5678);
        check_csr("unlisted_zero", 12'h340, 32'd0);
        irq_ext = 1'b1; irq_timer = 1'b1; irq_soft = 1'b1;
        check_csr("mip_lines", 12'h344, 32'h0000_0888);
        clear_events();

        // Illegal-instruction trap, direct redirect with 2-cycle latency
        csr_write(12'h305, 32'h8000_0100);
        exp_q.push_back(32'h8000_0100); pushed++;
        ex_valid = 1'b1; ex_cause = 31'd2; commit_pc = 32'h1004; ex_tval = 32'hDEAD;
        tick();
        clear_events();
        check("ex_flush_req", {31'd0, flush_req}, 32'd1);
        check("ex_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ex_latency", {31'd0, redirect_valid}, 32'd1);
        wait_idle(10);
        check_csr("ex_mepc", 12'h341, 32'h0000_1004);
        check_csr("ex_mcause", 12'h342, 32'h0000_0002);
        check_csr("ex_mtval", 12'h343, 32'h0000_DEAD);

        // Vectored timer interrupt
        csr_write(12'h305, 32'h8000_0101);
        csr_write(12'h304, 32'h0000_0080);
        csr_write(12'h300, 32'h0000_0008);
        check_csr("mti_pre_mstatus", 12'h300, 32'h0000_1808);
        exp_q.push_back(32'h8000_011C); pushed++;
        irq_timer = 1'b1; commit_pc = 32'h3000;
        tick();
        clear_events();
        wait_idle(10);
        check_csr("mti_mcause", 12'h342, 32'h8000_0007);
        check_csr("mti_mstatus", 12'h300, 32'h0000_1880);
        check_csr("mti_mtval", 12'h343, 32'd0);
        check_csr("mti_mepc", 12'h341, 32'h0000_3000);

        // Exception + MRET + MEI + CSR write in one cycle: exception wins
        csr_write(12'h300, 32'h0000_0088);
        csr_write(12'h304, 32'h0000_0800);
        exp_q.push_back(32'h8000_0100); pushed++;
        ex_valid = 1'b1; ex_cause = 31'd11; commit_pc = 32'h4002; ex_tval = 32'h55;
        mret_valid = 1'b1; irq_ext = 1'b1;
        csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h7777;
        tick();
        clear_events();
        wait_idle(10);
        check_csr("sim_mcause", 12'h342, 32'h0000_000B);
        check_csr("sim_mstatus", 12'h300, 32'h0000_1880);
        check_csr("sim_mepc_hw_wins", 12'h341, 32'h0000_4000);

        // MRET
        csr_write(12'h341, 32'h0000_2000);
        csr_write(12'h300, 32'h0000_0080);
        exp_q.push_back(32'h0000_2000); pushed++;
        mret_valid = 1'b1;
        tick();
        clear_events();
        wait_idle(10);
        check_csr("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_one_pulse", pulses, 4);

        // Flush stall: events and CSR writes during FLUSH are ignored
        flush_ack = 1'b0;
        exp_q.push_back(32'h8000_0100); pushed++;
        ex_valid = 1'b1; ex_cause = 31'd5; commit_pc = 32'h5000; ex_tval = 32'h77;
        tick();
        clear_events();
        flush_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (flush_req) flush_cnt++;
            check("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
            ex_valid = 1'b1; ex_cause = 31'd3; mret_valid = 1'b1; irq_ext = 1'b1;
            csr_wen = 1'b1; csr_addr = 12'h343; csr_wdata = 32'hBAD;
            tick();
        end
        if (flush_req) flush_cnt++;
        clear_events();
        flush_ack = 1'b1;
        tick();
        check("stall_flush_cycles", flush_cnt, 6);
        check("stall_redirect", {31'd0, redirect_valid}, 32'd1);
        wait_idle(10);
        tick();
        check("stall_no_requeue", {31'd0, busy}, 32'd0);
        check_csr("stall_mcause", 12'h342, 32'h0000_0005);
        check_csr("stall_mtval", 12'h343, 32'h0000_0077);

        // Reset mid-FLUSH
        flush_ack = 1'b0;
        ex_valid = 1'b1; ex_cause = 31'd2; commit_pc = 32'h6000;
        tick();
        clear_events();
        check("rstf_flush_req_before", {31'd0, flush_req}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("rstf_flush_req_async", {31'd0, flush_req}, 32'd0);
        check("rstf_busy_async", {31'd0, busy}, 32'd0);
        tick();
        nRST = 1'b1;
        flush_ack = 1'b1;
        tick();
        check("rstf_state_idle", {30'd0, fsm_state}, 32'd0);
        check_csr("rstf_mtvec", 12'h305, MTVEC_RST);
        check_csr("rstf_mepc", 12'h341, 32'd0);

        // Interrupt priority MEI > MSI > MTI, vectored
        csr_write(12'h305, 32'h8000_0101);
        csr_write(12'h304, 32'h0000_0888);
        csr_write(12'h300, 32'h0000_0008);
        exp_q.push_back(32'h8000_012C); pushed++;
        irq_ext = 1'b1; irq_soft = 1'b1; irq_timer = 1'b1;
        tick();
        irq_ext = 1'b0;
        wait_idle(10);
        check_csr("mei_mcause", 12'h342, 32'h8000_000B);
        exp_q.push_back(32'h8000_010C); pushed++;
        csr_write(12'h300, 32'h0000_0008);
        tick();
        clear_events();
        wait_idle(10);
        check_csr("msi_mcause", 12'h342, 32'h8000_0003);
        check_csr("msi_mstatus", 12'h300, 32'h0000_1880);

        // Drain and final report
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        check("pulse_count", pulses, pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
